// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues credit-limited imem requests and buffers
// returned instructions with their fetch PCs in an in-order queue.
module fetch_unit #(
   parameter int PC_W = 13,
   parameter int INSTR_W = 16,
   parameter int DEPTH = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [PC_W-1:0]    branch_pc,
   input  logic               stall,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    pc_out
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [CW:0] LIM = (CW + 1)'(DEPTH);
   logic [PC_W-1:0] pc;
   logic [CW-1:0] count, inflight, drop;
   logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
   logic [INSTR_W-1:0] q_instr [DEPTH];
   logic [PC_W-1:0] q_pc [DEPTH];
   logic [PC_W-1:0] tag [DEPTH];
   logic issue, push, pop;
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
   endfunction
   // Credit: every outstanding request is guaranteed a free queue slot on return
   assign imem_req = !rst && !flush && ({1'b0, inflight} + {1'b0, count}) < LIM;
   assign imem_addr = pc;
   assign issue = imem_req && imem_gnt;
   assign push = imem_rvalid && drop == '0 && !flush;
   assign pop = instr_valid && !stall && !flush;
   assign instr_valid = count != '0;
   assign instr_out = q_instr[rd_ptr];
   assign pc_out = q_pc[rd_ptr];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
         count <= '0;
         inflight <= '0;
         drop <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         tag_rd <= '0;
         tag_wr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_instr[i] <= '0;
            q_pc[i] <= '0;
            tag[i] <= '0;
         end
      end else begin
         inflight <= inflight + CW'(issue) - CW'(imem_rvalid);
         if (issue) begin
            tag[tag_wr] <= pc;
            tag_wr <= nxt(tag_wr);
            pc <= pc + PC_W'(1);
         end
         // Tags are consumed by every response, including ones being dropped
         if (imem_rvalid) tag_rd <= nxt(tag_rd);
         if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr] <= tag[tag_rd];
         end
         if (flush) begin
            pc <= branch_pc;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            drop <= inflight - CW'(imem_rvalid);
         end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
            if (imem_rvalid && drop != '0) drop <= drop - CW'(1);
         end
      end
   end
endmodule
